// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 5-stage pipeline: EX/MEM register, data-memory handshake,
// load formatting, MEM/WB register and the pipeline-wide data stall.
module mem_stage_ctrl #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [31:0]            ex_pc_plus4,
    input  logic [31:0]            ex_logic_out,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_regfile_we,
    input  logic [1:0]             ex_wb_sel,
    input  logic                   ex_mem_read,
    input  logic                   ex_mem_write,
    input  logic [2:0]             ex_load_funct3,
    input  logic [31:0]            ex_mem_wdata,
    input  logic [3:0]             ex_wmask,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [31:0]            dmem_address,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_byte_en,
    input  logic                   dmem_resp,
    input  logic [31:0]            dmem_rdata,
    output logic                   mem_stall,
    output logic [31:0]            mem_logic_out,
    output logic [4:0]             mem_rd,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd,
    output logic                   wb_we,
    output logic [31:0]            wb_data,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // state  | meaning
    // IDLE   | no access outstanding beyond the cycle an op entered the stage
    // ACCESS | a load/store is waiting for dmem_resp
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state, state_next;

    logic        s_valid;
    logic [31:0] s_pc_plus4;
    logic [31:0] s_logic_out;
    logic [4:0]  s_rd;
    logic        s_regfile_we;
    logic [1:0]  s_wb_sel;
    logic        s_mem_read;
    logic        s_mem_write;
    logic [2:0]  s_load_funct3;
    logic [31:0] s_mem_wdata;
    logic [3:0]  s_wmask;

    logic        mem_op;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_data_next;

    // The stage only advances once the access completes, so "no resp yet this
    // access" holds for as long as a memory op sits in the stage.
    assign mem_op        = s_valid & (s_mem_read | s_mem_write);
    assign dmem_read     = s_valid & s_mem_read;
    assign dmem_write    = s_valid & s_mem_write & ~s_mem_read;
    assign dmem_address  = {s_logic_out[31:2], 2'b00};
    assign dmem_wdata    = s_mem_wdata;
    assign dmem_byte_en  = s_wmask;
    assign mem_stall     = mem_op & ~dmem_resp;
    assign mem_logic_out = s_logic_out;
    assign mem_rd        = (s_valid & s_regfile_we) ? s_rd : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid       <= 1'b0;
            s_pc_plus4    <= 32'd0;
            s_logic_out   <= 32'd0;
            s_rd          <= 5'd0;
            s_regfile_we  <= 1'b0;
            s_wb_sel      <= 2'd0;
            s_mem_read    <= 1'b0;
            s_mem_write   <= 1'b0;
            s_load_funct3 <= 3'd0;
            s_mem_wdata   <= 32'd0;
            s_wmask       <= 4'd0;
        end else if (!mem_stall) begin
            s_valid       <= ex_valid;
            s_pc_plus4    <= ex_pc_plus4;
            s_logic_out   <= ex_logic_out;
            s_rd          <= ex_rd;
            s_regfile_we  <= ex_regfile_we;
            s_wb_sel      <= ex_wb_sel;
            s_mem_read    <= ex_mem_read;
            s_mem_write   <= ex_mem_write;
            s_load_funct3 <= ex_load_funct3;
            s_mem_wdata   <= ex_mem_wdata;
            s_wmask       <= ex_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A resp with no request outstanding never changes state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_op && !dmem_resp) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ld_byte = 8'd0;
        case (s_logic_out[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = s_logic_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    always_comb begin
        ld_data = dmem_rdata;
        case (s_load_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = dmem_rdata;
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        wb_data_next = s_logic_out;
        case (s_wb_sel)
            2'd1:    wb_data_next = ld_data;
            2'd2:    wb_data_next = s_pc_plus4;
            default: wb_data_next = s_logic_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_we    <= 1'b0;
            wb_data  <= 32'd0;
        end else if (!mem_stall) begin
            wb_valid <= s_valid;
            wb_rd    <= s_rd;
            wb_we    <= s_regfile_we & s_valid & (s_rd != 5'd0);
            wb_data  <= wb_data_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (mem_stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
